// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronises and debounces the A/B channels, then
// decodes Gray-code transitions into a registered position with step/dir/err.
//
// state   | meaning
// ST_INIT | filtered pair tracks synced inputs, waiting for both to settle
// ST_RUN  | per-channel filters active, transitions decoded and counted
module quad_decoder #(
   parameter int POS_WIDTH     = 8,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int COUNT_MODE    = 4,
   parameter int SATURATE      = 0
) (
   input  logic                 sysclk,
   input  logic                 rst,
   input  logic                 enc_a_raw,
   input  logic                 enc_b_raw,
   input  logic                 clear,
   output logic [POS_WIDTH-1:0] position,
   output logic                 step,
   output logic                 dir,
   output logic                 err
);
   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [7:0]           FILT_TC = 8'(FILTER_CYCLES - 1);
   localparam logic [POS_WIDTH-1:0] POS_MAX = '1;
   localparam logic [POS_WIDTH-1:0] POS_ONE = {{(POS_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
   logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
   logic [1:0]             synced;
   logic [1:0]             filt_q, filt_d;
   logic [1:0]             prev_q, prev_d;
   logic [7:0]             flt_cnt_q [2];
   logic [7:0]             flt_cnt_d [2];
   logic [7:0]             init_cnt_q, init_cnt_d;
   logic [POS_WIDTH-1:0]   pos_q, pos_d;
   logic                   step_q, step_d;
   logic                   dir_q, dir_d;
   logic                   err_q, err_d;
   logic                   moved, illegal, fwd, entering_count, count_evt;

   always_comb begin
      a_sync_d = {a_sync_q[SYNC_STAGES-2:0], enc_a_raw};
      b_sync_d = {b_sync_q[SYNC_STAGES-2:0], enc_b_raw};
   end

   // Pair ordering is {a, b} throughout: bit 1 = channel A, bit 0 = channel B.
   assign synced = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

   always_comb begin
      state_d      = state_q;
      filt_d       = filt_q;
      prev_d       = filt_q;
      init_cnt_d   = '0;
      flt_cnt_d[0] = '0;
      flt_cnt_d[1] = '0;
      case (state_q)
         ST_INIT: begin
            filt_d = synced;
            if (synced == filt_q) begin
               if (init_cnt_q == FILT_TC) state_d = ST_RUN;
               else init_cnt_d = init_cnt_q + 8'd1;
            end
         end
         ST_RUN: begin
            for (int i = 0; i < 2; i++) begin
               if (synced[i] != filt_q[i]) begin
                  if (flt_cnt_q[i] == FILT_TC) filt_d[i] = synced[i];
                  else flt_cnt_d[i] = flt_cnt_q[i] + 8'd1;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_comb begin
      moved   = (state_q == ST_RUN) && (prev_q != filt_q);
      illegal = moved && (prev_q[1] != filt_q[1]) && (prev_q[0] != filt_q[0]);
      case ({prev_q, filt_q})
         4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
         default:                                fwd = 1'b0;
      endcase
      case (COUNT_MODE)
         1:       entering_count = (filt_q == 2'b00);
         2:       entering_count = (filt_q == 2'b00) || (filt_q == 2'b11);
         default: entering_count = 1'b1;
      endcase
      count_evt = moved && !illegal && entering_count;
   end

   // clear overrides both the position update and a simultaneous illegal move.
   always_comb begin
      pos_d  = pos_q;
      step_d = count_evt;
      dir_d  = dir_q;
      err_d  = err_q | illegal;
      if (count_evt) begin
         dir_d = fwd;
         if (fwd) begin
            if (!((SATURATE != 0) && (pos_q == POS_MAX))) pos_d = pos_q + POS_ONE;
         end else begin
            if (!((SATURATE != 0) && (pos_q == '0))) pos_d = pos_q - POS_ONE;
         end
      end
      if (clear) begin
         pos_d = '0;
         err_d = 1'b0;
      end
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_INIT;
         a_sync_q     <= '0;
         b_sync_q     <= '0;
         filt_q       <= '0;
         prev_q       <= '0;
         flt_cnt_q[0] <= '0;
         flt_cnt_q[1] <= '0;
         init_cnt_q   <= '0;
         pos_q        <= '0;
         step_q       <= 1'b0;
         dir_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_sync_q     <= a_sync_d;
         b_sync_q     <= b_sync_d;
         filt_q       <= filt_d;
         prev_q       <= prev_d;
         flt_cnt_q[0] <= flt_cnt_d[0];
         flt_cnt_q[1] <= flt_cnt_d[1];
         init_cnt_q   <= init_cnt_d;
         pos_q        <= pos_d;
         step_q       <= step_d;
         dir_q        <= dir_d;
         err_q        <= err_d;
      end
   end

   assign position = pos_q;
   assign step     = step_q;
   assign dir      = dir_q;
   assign err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: four parameter variants driven from shared inputs,
// checked against a phase-arithmetic reference model.
module tb_quad_decoder;
   localparam int S = 2;
   localparam int F = 4;

   logic sysclk = 1'b0;
   logic rst = 1'b1;
   logic enc_a_raw = 1'b0;
   logic enc_b_raw = 1'b0;
   logic clear = 1'b0;

   logic [7:0] pos_o  [4];
   logic       step_o [4];
   logic       dir_o  [4];
   logic       err_o  [4];

   int checks = 0;
   int errors = 0;
   int dut_steps [4] = '{0, 0, 0, 0};

   // instance 0: defaults, 1: saturating, 2: COUNT_MODE 1, 3: COUNT_MODE 2
   int m_mode [4] = '{4, 4, 1, 2};
   int m_sat  [4] = '{0, 1, 0, 0};
   logic [1:0] ring [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   quad_decoder u_def (.sysclk(sysclk), .rst(rst), .enc_a_raw(enc_a_raw), .enc_b_raw(enc_b_raw),
      .clear(clear), .position(pos_o[0]), .step(step_o[0]), .dir(dir_o[0]), .err(err_o[0]));
   quad_decoder #(.SATURATE(1)) u_sat (.sysclk(sysclk), .rst(rst), .enc_a_raw(enc_a_raw),
      .enc_b_raw(enc_b_raw), .clear(clear), .position(pos_o[1]), .step(step_o[1]),
      .dir(dir_o[1]), .err(err_o[1]));
   quad_decoder #(.COUNT_MODE(1)) u_m1 (.sysclk(sysclk), .rst(rst), .enc_a_raw(enc_a_raw),
      .enc_b_raw(enc_b_raw), .clear(clear), .position(pos_o[2]), .step(step_o[2]),
      .dir(dir_o[2]), .err(err_o[2]));
   quad_decoder #(.COUNT_MODE(2)) u_m2 (.sysclk(sysclk), .rst(rst), .enc_a_raw(enc_a_raw),
      .enc_b_raw(enc_b_raw), .clear(clear), .position(pos_o[3]), .step(step_o[3]),
      .dir(dir_o[3]), .err(err_o[3]));

   always #5 sysclk = ~sysclk;

   always @(negedge sysclk) begin
      for (int k = 0; k < 4; k++) if (step_o[k] === 1'b1) dut_steps[k]++;
   end

   // Reference model: raw history queue for the synchroniser delay, run-length
   // debounce, and transitions classified by phase difference modulo 4.
   logic [1:0] raw_hist [$];
   logic [1:0] m_syn, m_filt, m_last;
   bit         m_run;
   int         stable_run, m_delta, m_ph;
   int         diff_run [2];
   int         m_pos [4];
   bit         m_step [4], m_dir [4], m_err [4];

   function automatic int phase(input logic [1:0] p);
      case (p)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   always @(posedge sysclk or posedge rst) begin
      if (rst) begin
         raw_hist.delete();
         for (int i = 0; i < S; i++) raw_hist.push_back(2'b00);
         m_filt = 2'b00; m_last = 2'b00; m_run = 1'b0; stable_run = 0;
         diff_run[0] = 0; diff_run[1] = 0;
         for (int k = 0; k < 4; k++) begin
            m_pos[k] = 0; m_step[k] = 1'b0; m_dir[k] = 1'b0; m_err[k] = 1'b0;
         end
      end else begin
         m_syn = raw_hist[S-1];
         for (int k = 0; k < 4; k++) m_step[k] = 1'b0;
         if (m_run && m_filt != m_last) begin
            m_delta = (phase(m_filt) - phase(m_last) + 4) % 4;
            m_ph = phase(m_filt);
            for (int k = 0; k < 4; k++) begin
               if (m_delta == 2) m_err[k] = 1'b1;
               else if (m_mode[k] == 4 || (m_mode[k] == 2 && m_ph % 2 == 0) ||
                        (m_mode[k] == 1 && m_ph == 0)) begin
                  m_step[k] = 1'b1;
                  m_dir[k] = (m_delta == 1);
                  if (m_delta == 1)
                     m_pos[k] = (m_sat[k] != 0) ? ((m_pos[k] == 255) ? 255 : m_pos[k] + 1)
                                                : (m_pos[k] + 1) % 256;
                  else
                     m_pos[k] = (m_sat[k] != 0) ? ((m_pos[k] == 0) ? 0 : m_pos[k] - 1)
                                                : (m_pos[k] + 255) % 256;
               end
            end
         end
         if (clear) for (int k = 0; k < 4; k++) begin m_pos[k] = 0; m_err[k] = 1'b0; end
         m_last = m_filt;
         if (!m_run) begin
            stable_run = (m_syn == m_filt) ? stable_run + 1 : 0;
            if (stable_run == F) begin m_run = 1'b1; stable_run = 0; end
            m_filt = m_syn;
         end else begin
            for (int c = 0; c < 2; c++) begin
               if (m_syn[c] != m_filt[c]) begin
                  diff_run[c]++;
                  if (diff_run[c] == F) begin m_filt[c] = m_syn[c]; diff_run[c] = 0; end
               end else diff_run[c] = 0;
            end
         end
         raw_hist.push_front({enc_a_raw, enc_b_raw});
         void'(raw_hist.pop_back());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   task automatic drive(input logic [1:0] ab);
      enc_a_raw = ab[1];
      enc_b_raw = ab[0];
   endtask

   task automatic test_reset();
      rst = 1'b1; drive(2'b00); clear = 1'b0;
      tick(3);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({pos_o[k], step_o[k], dir_o[k], err_o[k]} !== 11'd0) begin
            errors++; $display("FAIL reset_state inst %0d got pos=%0d step=%b dir=%b err=%b want 0",
                               k, pos_o[k], step_o[k], dir_o[k], err_o[k]);
         end
      end
      rst = 1'b0;
      tick(12);
      checks++;
      if (pos_o[0] !== 8'd0 || err_o[0] !== 1'b0 || dut_steps[0] !== 0) begin
         errors++; $display("FAIL post_reset got pos=%0d err=%b steps=%0d want 0/0/0",
                            pos_o[0], err_o[0], dut_steps[0]);
      end
   endtask

   task automatic test_forward();
      int base;
      base = dut_steps[0];
      for (int c = 0; c < 4; c++)
         for (int i = 1; i <= 4; i++) begin drive(ring[i % 4]); tick(8); end
      tick(8);
      checks++;
      if (pos_o[0] !== 8'd16) begin errors++; $display("FAIL fwd_pos got %0d want 16", pos_o[0]); end
      checks++;
      if (dut_steps[0] - base !== 16) begin
         errors++; $display("FAIL fwd_steps got %0d want 16", dut_steps[0] - base);
      end
      checks++;
      if (dir_o[0] !== 1'b1 || err_o[0] !== 1'b0) begin
         errors++; $display("FAIL fwd_dir_err got dir=%b err=%b want 1/0", dir_o[0], err_o[0]);
      end
      checks++;
      if (pos_o[1] !== 8'd16) begin errors++; $display("FAIL fwd_sat_pos got %0d want 16", pos_o[1]); end
      checks++;
      if (pos_o[2] !== 8'd4) begin errors++; $display("FAIL fwd_mode1_pos got %0d want 4", pos_o[2]); end
      checks++;
      if (pos_o[3] !== 8'd8) begin errors++; $display("FAIL fwd_mode2_pos got %0d want 8", pos_o[3]); end
   endtask

   task automatic test_latency();
      logic [7:0] p0;
      int lat;
      p0 = pos_o[0]; lat = 0;
      drive(2'b01);
      for (int i = 0; i < 20 && pos_o[0] === p0; i++) begin tick(1); lat++; end
      checks++;
      if (lat !== 7) begin errors++; $display("FAIL latency_mode4 got %0d cycles want 7", lat); end
      tick(8);
      p0 = pos_o[3]; lat = 0;
      drive(2'b11);
      for (int i = 0; i < 20 && pos_o[3] === p0; i++) begin tick(1); lat++; end
      checks++;
      if (lat !== 7) begin errors++; $display("FAIL latency_mode2 got %0d cycles want 7", lat); end
      tick(8); drive(2'b10); tick(10); drive(2'b00); tick(10);
      checks++;
      if (pos_o[0] !== 8'd20 || pos_o[2] !== 8'd5 || pos_o[3] !== 8'd10) begin
         errors++; $display("FAIL latency_cycle_pos got %0d/%0d/%0d want 20/5/10",
                            pos_o[0], pos_o[2], pos_o[3]);
      end
   endtask

   task automatic test_clear_priority();
      drive(2'b01); tick(6);
      clear = 1'b1; tick(1); clear = 1'b0;
      checks++;
      if (pos_o[0] !== 8'd0 || step_o[0] !== 1'b1 || dir_o[0] !== 1'b1) begin
         errors++; $display("FAIL clear_vs_count got pos=%0d step=%b dir=%b want 0/1/1",
                            pos_o[0], step_o[0], dir_o[0]);
      end
      tick(4);
      drive(2'b10); tick(6);
      clear = 1'b1; tick(1); clear = 1'b0;
      tick(3);
      checks++;
      if (err_o[0] !== 1'b0 || pos_o[0] !== 8'd0) begin
         errors++; $display("FAIL clear_vs_illegal got err=%b pos=%0d want 0/0", err_o[0], pos_o[0]);
      end
      drive(2'b00); tick(10);
      checks++;
      if (pos_o[0] !== 8'd1) begin errors++; $display("FAIL clear_resume got %0d want 1", pos_o[0]); end
   endtask

   task automatic test_reverse();
      int base;
      clear = 1'b1; tick(1); clear = 1'b0;
      base = dut_steps[1];
      drive(2'b10); tick(10);
      checks++;
      if (pos_o[0] !== 8'd255 || dir_o[0] !== 1'b0) begin
         errors++; $display("FAIL rev_wrap got pos=%0d dir=%b want 255/0", pos_o[0], dir_o[0]);
      end
      checks++;
      if (pos_o[1] !== 8'd0 || dir_o[1] !== 1'b0 || dut_steps[1] - base !== 1) begin
         errors++; $display("FAIL rev_sat got pos=%0d dir=%b steps=%0d want 0/0/1",
                            pos_o[1], dir_o[1], dut_steps[1] - base);
      end
      checks++;
      if (pos_o[2] !== 8'd0) begin errors++; $display("FAIL rev_mode1 got %0d want 0", pos_o[2]); end
      drive(2'b00); tick(10);
      checks++;
      if (pos_o[0] !== 8'd0 || pos_o[1] !== 8'd1) begin
         errors++; $display("FAIL rev_return got %0d/%0d want 0/1", pos_o[0], pos_o[1]);
      end
   endtask

   task automatic test_glitch();
      int base;
      clear = 1'b1; tick(1); clear = 1'b0;
      tick(2);
      base = dut_steps[0];
      enc_a_raw = 1'b1; tick(3); enc_a_raw = 1'b0; tick(12);
      checks++;
      if (pos_o[0] !== 8'd0 || dut_steps[0] !== base || err_o[0] !== 1'b0) begin
         errors++; $display("FAIL glitch3 got pos=%0d steps=%0d err=%b want 0/0/0",
                            pos_o[0], dut_steps[0] - base, err_o[0]);
      end
      enc_a_raw = 1'b1; tick(4); enc_a_raw = 1'b0; tick(12);
      checks++;
      if (pos_o[0] !== 8'd0 || dut_steps[0] - base !== 2 || err_o[0] !== 1'b0) begin
         errors++; $display("FAIL pulse4 got pos=%0d steps=%0d err=%b want 0/2/0",
                            pos_o[0], dut_steps[0] - base, err_o[0]);
      end
   endtask

   task automatic test_illegal();
      drive(2'b01); tick(10);
      drive(2'b10); tick(10);
      checks++;
      if (err_o[0] !== 1'b1 || pos_o[0] !== 8'd1) begin
         errors++; $display("FAIL illegal_err got err=%b pos=%0d want 1/1", err_o[0], pos_o[0]);
      end
      tick(5);
      checks++;
      if (err_o[0] !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_o[0]); end
      clear = 1'b1; tick(1); clear = 1'b0;
      checks++;
      if (err_o[0] !== 1'b0 || pos_o[0] !== 8'd0) begin
         errors++; $display("FAIL illegal_clear got err=%b pos=%0d want 0/0", err_o[0], pos_o[0]);
      end
      drive(2'b00); tick(10);
   endtask

   task automatic test_random();
      logic [1:0] cur, nxt;
      int dwell, ph;
      cur = {enc_a_raw, enc_b_raw};
      for (int s = 0; s < 250; s++) begin
         ph = phase(cur);
         case ($urandom_range(0, 5))
            0, 1, 2: nxt = ring[(ph + 1) % 4];
            3:       nxt = ring[(ph + 3) % 4];
            4:       nxt = 2'($urandom_range(0, 3));
            default: nxt = cur;
         endcase
         drive(nxt); cur = nxt;
         clear = ($urandom_range(0, 30) == 0);
         dwell = $urandom_range(1, 12);
         for (int c = 0; c < dwell; c++) begin
            tick(1); clear = 1'b0;
            for (int k = 0; k < 4; k++) begin
               checks++;
               if ({pos_o[k], step_o[k], dir_o[k], err_o[k]} !==
                   {8'(m_pos[k]), m_step[k], m_dir[k], m_err[k]}) begin
                  errors++;
                  if (errors <= 20)
                     $display("FAIL random inst %0d got pos=%0d step=%b dir=%b err=%b want %0d/%b/%b/%b",
                              k, pos_o[k], step_o[k], dir_o[k], err_o[k],
                              m_pos[k], m_step[k], m_dir[k], m_err[k]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(2'b00); tick(10);
      drive(2'b11); tick(3);
      rst = 1'b1; tick(2); rst = 1'b0;
      for (int c = 0; c < 15; c++) begin
         tick(1);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (step_o[k] !== 1'b0 || err_o[k] !== 1'b0 || pos_o[k] !== 8'd0) begin
               errors++; $display("FAIL reset_mid inst %0d got step=%b err=%b pos=%0d want 0/0/0",
                                  k, step_o[k], err_o[k], pos_o[k]);
            end
         end
      end
      drive(2'b10); tick(10);
      checks++;
      if (pos_o[0] !== 8'd1 || dir_o[0] !== 1'b1 || err_o[0] !== 1'b0) begin
         errors++; $display("FAIL run_from_11 got pos=%0d dir=%b err=%b want 1/1/0",
                            pos_o[0], dir_o[0], err_o[0]);
      end
      checks++;
      if (pos_o[2] !== 8'(m_pos[2]) || pos_o[3] !== 8'(m_pos[3])) begin
         errors++; $display("FAIL run_from_11_modes got %0d/%0d want %0d/%0d",
                            pos_o[2], pos_o[3], m_pos[2], m_pos[3]);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_latency();
      test_clear_priority();
      test_reverse();
      test_glitch();
      test_illegal();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter POS_WIDTH, default 8: position counter width, legal range 2..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth per input, legal range 2..4.
REQ-003 SHALL have parameter FILTER_CYCLES, default 4: consecutive stable samples required before a filtered input changes, legal range 1..255.
REQ-004 SHALL have parameter COUNT_MODE, default 4: counts per quadrature cycle, legal values 1, 2, 4.
REQ-005 SHALL have parameter SATURATE, default 0: 0 means position wraps, 1 means position clamps.
REQ-006 SHALL have port sysclk, input, 1 bit: the single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have ports enc_a_raw and enc_b_raw, input, 1 bit each: asynchronous encoder channels.
REQ-009 SHALL have port clear, input, 1 bit: synchronous clear of position and err.
REQ-010 SHALL have port position, output, POS_WIDTH bits: unsigned count, registered.
REQ-011 SHALL have port step, output, 1 bit: one-cycle pulse per counted event.
REQ-012 SHALL have port dir, output, 1 bit: direction of last counted event, 1 = forward.
REQ-013 SHALL have port err, output, 1 bit: sticky flag for illegal transitions.

Function
REQ-014 SHALL pass each raw input through a SYNC_STAGES flop chain; the last stage is the synced value.
REQ-015 Per channel: a counter SHALL run while synced != filtered and reset to 0 whenever synced == filtered; the filtered value SHALL take the synced value on the edge completing FILTER_CYCLES consecutive differing samples.
REQ-016 SHALL implement FSM states INIT and RUN: INIT loads the filtered values from the synced values with no count and no err; INIT→RUN once both channels have been stable for FILTER_CYCLES cycles.
REQ-017 In RUN, the previous filtered pair {a,b} SHALL be compared with the current filtered pair each cycle.
REQ-018 Forward sequence SHALL be 00→01→11→10→00; the reverse sequence SHALL be backward.
REQ-019 A change of both bits SHALL set err, with no count and no step.
REQ-020 COUNT_MODE 4 SHALL count every legal transition; mode 2 only transitions entering 00 or 11; mode 1 only transitions entering 00.
REQ-021 A counted event SHALL, on the next edge: position ±1, step=1 for one cycle, dir=1 forward / 0 backward.
REQ-022 Latency SHALL be: the position change is visible after rising edge SYNC_STAGES+FILTER_CYCLES+1 following a stable raw edge.
REQ-023 Pulses shorter than FILTER_CYCLES cycles at the synced output SHALL produce no filtered change, count or err.
REQ-024 With SATURATE=0, position SHALL wrap modulo 2^POS_WIDTH (max+1→0, 0−1→max).
REQ-025 With SATURATE=1, position SHALL hold at 0 and at 2^POS_WIDTH−1; step and dir still update.
REQ-026 clear SHALL set position=0 and err=0 on the next edge; clear wins over a simultaneous count (step still pulses, position=0) and over a simultaneous illegal transition (err=0).
REQ-027 err SHALL remain set until clear or rst.

Reset
REQ-028 While rst=1, SHALL force: all sync flops, filtered values and filter counters to 0; FSM=INIT; position=0, step=0, dir=0, err=0.
REQ-029 Reset asserted mid-operation SHALL abort any pending filter count; no spurious step or err after release, regardless of input levels.

Verification
REQ-030 Default params; reset, inputs held 00, then drive four forward quadrature cycles (8-cycle dwell per state) → position=16, 16 step pulses, dir=1, err=0.
REQ-031 Defaults; from position 0, one reverse transition → position=255, dir=0; with SATURATE=1 → position stays 0, step pulses once.
REQ-032 Defaults; 3-cycle glitch on enc_a_raw → no change to position, step or err; 4-cycle pulse → one count each way, net position 0.
REQ-033 Defaults; filtered 00→11 in one step → err=1, position unchanged; assert clear → err=0, position=0 next cycle.
REQ-034 COUNT_MODE=1, one full forward cycle → position=1; COUNT_MODE=2 → position=2; edge-to-count latency measured as 7 cycles.
REQ-035 Release rst with inputs at 11 → FSM reaches RUN, position=0, err=0, no step; then drive forward transition 11→10 → position=1.
